sync_fifo_flags: RTL

- Single-clock, parametrised FIFO. It is the same-domain successor to the team's dual-clock FIFO, used where producer and consumer share one clock and no pointer synchronisation is needed.
- Adds the following over the dual-clock FIFO:
  - occupancy count output
  - programmable almost-full / almost-empty flags
  - selectable first-word-fall-through (FWFT) or registered-read mode
  - sticky overflow/underflow error flags with clear
- Sits between a producer and consumer in one clock domain, e.g. staging buffers ahead of the CDC FIFO.

---
 rtl/sync_fifo_flags.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Single-clock FIFO with occupancy count, programmable almost-full /
//   almost-empty flags, selectable first-word-fall-through or registered-read
//   output, and sticky overflow/underflow error flags.
//
// Ports
//   clock            sole clock, rising edge
//   reset            synchronous, active-high; priority over all other inputs
//   write_data       word to push
//   write_increment  push request (accepted when !full)
//   full             count == DEPTH
//   almost_full      count >= ALMOST_FULL_LEVEL
//   read_increment   pop request (accepted when !empty)
//   read_data        FWFT=0: loaded on an accepted pop (1-cycle latency)
//                    FWFT=1: head word whenever !empty, 0 when empty
//   empty            count == 0
//   almost_empty     count <= ALMOST_EMPTY_LEVEL
//   count            occupancy, 0..DEPTH
//   clear_errors     clears overflow/underflow at the next edge
//   overflow         sticky: push attempted while full
//   underflow        sticky: pop attempted while empty
module sync_fifo_flags #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int FWFT               = 0,
    parameter int ALMOST_FULL_LEVEL  = 2**ADDRESS_WIDTH - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     write_increment,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     read_increment,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   count,
    input  logic                     clear_errors,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT = DEPTH[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] AF_LEVEL  = ALMOST_FULL_LEVEL[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] AE_LEVEL  = ALMOST_EMPTY_LEVEL[ADDRESS_WIDTH:0];

    logic [DATA_WIDTH-1:0]    mem [0:DEPTH-1];
    logic [ADDRESS_WIDTH-1:0] wptr;
    logic [ADDRESS_WIDTH-1:0] rptr;
    logic [ADDRESS_WIDTH:0]   count_q;
    logic                     push_ok;
    logic                     pop_ok;

    // Acceptance uses the flags of the current state, so a push into a full
    // FIFO is rejected even when a pop in the same cycle frees a slot.
    assign push_ok = write_increment && !full;
    assign pop_ok  = read_increment && !empty;

    assign count        = count_q;
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_LEVEL);
    assign almost_empty = (count_q <= AE_LEVEL);

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
            mem[wptr] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A new error in the same cycle as clear_errors keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_increment && full) begin
                overflow <= 1'b1;
            end else if (clear_errors) begin
                overflow <= 1'b0;
            end
            if (read_increment && empty) begin
                underflow <= 1'b1;
            end else if (clear_errors) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign read_data = empty ? '0 : mem[rptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] read_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    read_q <= '0;
                end else if (pop_ok) begin
                    read_q <= mem[rptr];
                end
            end

            assign read_data = read_q;
        end
    endgenerate

endmodule
